// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives inst_rom, buffers fetched words in a
// 2-entry queue for decode. Optional out-of-range fetch check via `IFETCH_BOUND_CHECK_EN.
module inst_fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        fetch_fault
);

    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29 || RESET_VECTOR[1:0] != 2'b00) begin : g_bad_params
        $error("inst_fetch_ctrl: ADDR_WIDTH out of range or RESET_VECTOR unaligned");
    end

    logic [31:0] pc_q, pc_d;
    logic [31:0] head_inst_q, head_inst_d, head_pc_q, head_pc_d;
    logic [31:0] tail_inst_q, tail_inst_d, tail_pc_q, tail_pc_d;
    logic [1:0]  count_q, count_d;
    logic        pop, can_fetch, oob, push;

    assign rom_addr   = reset ? RESET_VECTOR : pc_q;
    assign inst_valid = (count_q != 2'd0);
    assign inst_data  = head_inst_q;
    assign inst_pc    = head_pc_q;
    assign halted     = halt_req & (count_q == 2'd0) & ~reset;

`ifdef IFETCH_BOUND_CHECK_EN
    logic fault_q;

    assign oob         = |(pc_q >> (ADDR_WIDTH + 2));
    assign fetch_fault = fault_q;

    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            fault_q <= 1'b0;
        end else if (can_fetch && oob) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign oob         = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Redirect suppresses the pop so the head shown that cycle is flushed, not consumed.
    assign pop       = inst_valid & inst_ready & ~redirect_valid;
    assign can_fetch = ~redirect_valid & ~halt_req & ((count_q != 2'd2) | pop);
    assign push      = can_fetch & ~oob;

    always_comb begin
        pc_d        = pc_q;
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
        tail_inst_d = tail_inst_q;
        tail_pc_d   = tail_pc_q;
        count_d     = count_q;
        if (redirect_valid) begin
            count_d = 2'd0;
            pc_d    = redirect_pc & ~32'h3;
        end else begin
            if (push) begin
                pc_d = pc_q + 32'd4;
            end
            case ({push, pop})
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_inst_d = tail_inst_q;
                        head_pc_d   = tail_pc_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_inst_d = rom_data;
                        head_pc_d   = pc_q;
                    end else begin
                        tail_inst_d = rom_data;
                        tail_pc_d   = pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_inst_d = rom_data;
                        head_pc_d   = pc_q;
                    end else begin
                        head_inst_d = tail_inst_q;
                        head_pc_d   = tail_pc_q;
                        tail_inst_d = rom_data;
                        tail_pc_d   = pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            head_inst_q <= '0;
            head_pc_q   <= '0;
            tail_inst_q <= '0;
            tail_pc_q   <= '0;
            count_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            head_inst_q <= head_inst_d;
            head_pc_q   <= head_pc_d;
            tail_inst_q <= tail_inst_d;
            tail_pc_q   <= tail_pc_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a behavioural inst_rom; outputs are checked at
// mid-cycle against hand-computed vectors.
module tb_inst_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        fetch_fault;

    logic [31:0] rom [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    assign rom_data = rom[rom_addr[9:2]];

    inst_fetch_ctrl #(
        .ADDR_WIDTH  (8),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .halted        (halted),
        .fetch_fault   (fetch_fault)
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rpc;
        logic        hlt;
        logic        cv, ev;
        logic        cdp;
        logic [31:0] ed, ep, ea;
        logic        eh;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, rdy, rv, input logic [31:0] rpc, input logic hlt,
                                input logic cv, ev, cdp, input logic [31:0] ed, ep, ea,
                                input logic eh);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
        v.cv = cv; v.ev = ev; v.cdp = cdp; v.ed = ed; v.ep = ep; v.ea = ea; v.eh = eh;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rst, rdy, rv, input logic [31:0] rpc, input logic hlt);
        @(negedge clock);
        reset          = rst;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hlt;
        #1;
    endtask

    // cv gates valid/fault checks, cdp gates data/pc checks; rom_addr and halted always checked
    task automatic expect_out(input string tag, input logic cv, ev, cdp,
                              input logic [31:0] ed, ep, ea, input logic eh, ef);
        check({tag, " rom_addr"}, rom_addr, ea);
        check({tag, " halted"}, {31'b0, halted}, {31'b0, eh});
        if (cv) begin
            check({tag, " inst_valid"}, {31'b0, inst_valid}, {31'b0, ev});
            check({tag, " fetch_fault"}, {31'b0, fetch_fault}, {31'b0, ef});
        end
        if (cdp) begin
            check({tag, " inst_data"}, inst_data, ed);
            check({tag, " inst_pc"}, inst_pc, ep);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 + i;
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;

        //              rst rdy rv rpc        hlt cv ev cdp data          pc        rom_addr  halted
        tbl.push_back(mk(1, 0, 0, 32'h0,     0,  0, 0, 0,  32'h0,        32'h0,    32'h0,    0));
        tbl.push_back(mk(1, 0, 0, 32'h0,     0,  1, 0, 1,  32'h0,        32'h0,    32'h0,    0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 0, 0,  32'h0,        32'h0,    32'h0,    0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 1, 1,  32'h11,       32'h0,    32'h4,    0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 1, 1,  32'h22,       32'h4,    32'h8,    0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 1, 1,  32'h33,       32'h8,    32'hC,    0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 1, 1,  32'h44,       32'hC,    32'h10,   0));
        tbl.push_back(mk(1, 1, 0, 32'h0,     0,  0, 0, 0,  32'h0,        32'h0,    32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     0,  1, 0, 1,  32'h0,        32'h0,    32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     0,  1, 1, 1,  32'h11,       32'h0,    32'h4,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     0,  1, 1, 1,  32'h11,       32'h0,    32'h8,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     0,  1, 1, 1,  32'h11,       32'h0,    32'h8,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     0,  1, 1, 1,  32'h11,       32'h0,    32'h8,    0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 1, 1,  32'h11,       32'h0,    32'h8,    0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 1, 1,  32'h22,       32'h4,    32'hC,    0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 1, 1,  32'h33,       32'h8,    32'h10,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     0,  1, 1, 1,  32'h44,       32'hC,    32'h14,   0));
        tbl.push_back(mk(0, 1, 1, 32'h43,    0,  1, 1, 1,  32'h44,       32'hC,    32'h14,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 0, 0,  32'h0,        32'h0,    32'h40,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 1, 1,  32'hA000_0010, 32'h40,  32'h44,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     0,  1, 1, 1,  32'hA000_0011, 32'h44,  32'h48,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     1,  1, 1, 1,  32'hA000_0011, 32'h44,  32'h4C,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     1,  1, 1, 1,  32'hA000_0012, 32'h48,  32'h4C,   0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     1,  1, 0, 0,  32'h0,        32'h0,    32'h4C,   1));
        tbl.push_back(mk(0, 1, 0, 32'h0,     1,  1, 0, 0,  32'h0,        32'h0,    32'h4C,   1));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 0, 0,  32'h0,        32'h0,    32'h4C,   0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     0,  1, 1, 1,  32'hA000_0013, 32'h4C,  32'h50,   0));
        tbl.push_back(mk(1, 1, 1, 32'h100,   0,  0, 0, 0,  32'h0,        32'h0,    32'h0,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     0,  1, 0, 1,  32'h0,        32'h0,    32'h0,    0));
        tbl.push_back(mk(0, 0, 1, 32'h82,    1,  1, 1, 1,  32'h11,       32'h0,    32'h4,    0));
        tbl.push_back(mk(0, 0, 0, 32'h0,     1,  1, 0, 0,  32'h0,        32'h0,    32'h80,   1));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 0, 0,  32'h0,        32'h0,    32'h80,   0));
        tbl.push_back(mk(0, 1, 1, 32'h200,   0,  1, 1, 1,  32'hA000_0020, 32'h80,  32'h84,   0));
        tbl.push_back(mk(0, 1, 1, 32'h104,   0,  1, 0, 0,  32'h0,        32'h0,    32'h200,  0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 0, 0,  32'h0,        32'h0,    32'h104,  0));
        tbl.push_back(mk(0, 1, 0, 32'h0,     0,  1, 1, 1,  32'hA000_0041, 32'h104, 32'h108,  0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, tbl[i].hlt);
            expect_out($sformatf("row%0d", i), tbl[i].cv, tbl[i].ev, tbl[i].cdp,
                       tbl[i].ed, tbl[i].ep, tbl[i].ea, tbl[i].eh, 1'b0);
        end

        // End of ROM: 0x3FC is the last in-range word, 0x400 is out of range / aliases word 0
        drive(1, 1, 0, 32'h0, 0);
        expect_out("bnd0", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        drive(0, 1, 1, 32'h3FC, 0);
        expect_out("bnd1", 1, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0);
        drive(0, 1, 0, 32'h0, 0);
        expect_out("bnd2", 1, 0, 0, 32'h0, 32'h0, 32'h3FC, 0, 0);
        drive(0, 1, 0, 32'h0, 0);
        expect_out("bnd3", 1, 1, 1, 32'hA000_00FF, 32'h3FC, 32'h400, 0, 0);
        drive(0, 1, 0, 32'h0, 0);
`ifdef IFETCH_BOUND_CHECK_EN
        expect_out("bnd4", 1, 0, 0, 32'h0, 32'h0, 32'h400, 0, 1);
        drive(0, 1, 0, 32'h0, 1);
        expect_out("bnd5", 1, 0, 0, 32'h0, 32'h0, 32'h400, 1, 1);
        drive(0, 1, 1, 32'h0, 0);
        expect_out("bnd6", 1, 0, 0, 32'h0, 32'h0, 32'h400, 0, 1);
`else
        expect_out("bnd4", 1, 1, 1, 32'h11, 32'h400, 32'h404, 0, 0);
        drive(0, 1, 0, 32'h0, 1);
        expect_out("bnd5", 1, 1, 1, 32'h22, 32'h404, 32'h408, 0, 0);
        drive(0, 1, 1, 32'h0, 0);
        expect_out("bnd6", 1, 0, 0, 32'h0, 32'h0, 32'h408, 0, 0);
`endif
        drive(0, 1, 0, 32'h0, 0);
        expect_out("bnd7", 1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        drive(0, 1, 0, 32'h0, 0);
        expect_out("bnd8", 1, 1, 1, 32'h11, 32'h0, 32'h4, 0, 0);

        // PC wrap at the top of the 32-bit address space
        drive(0, 1, 1, 32'hFFFF_FFFC, 0);
        expect_out("wrap0", 1, 1, 1, 32'h22, 32'h4, 32'h8, 0, 0);
        drive(0, 1, 0, 32'h0, 0);
        expect_out("wrap1", 1, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0, 0);
        drive(0, 1, 0, 32'h0, 0);
`ifdef IFETCH_BOUND_CHECK_EN
        expect_out("wrap2", 1, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0, 1);
`else
        expect_out("wrap2", 1, 1, 1, 32'hA000_00FF, 32'hFFFF_FFFC, 32'h0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
